mario_jump_ctrl: RTL and testbench
==================================

Name: mario_jump_ctrl

Overview:
Vertical-motion sequencer for the hero sprite. It turns the jump button, a physics tick and the collision floor level into a hero y coordinate and an airborne status. The sprite/animation block uses airborne to freeze the walk cycle; the renderer uses y.
Screen coordinates: y grows downward. Velocity is an unsigned magnitude; the FSM state gives the direction.

Parameters:
GROUND_Y, 400, reset y position and default floor (11-bit)
CEIL_Y, 16, minimum legal y; head clamps here
JUMP_V0, 12, initial upward speed, px/tick (6-bit)
GRAVITY, 1, speed change per tick (6-bit, must be ≥1)
MAX_FALL_V, 12, terminal fall speed, px/tick
JUMP_CUT_V, 4, speed cap after early release (optional feature only)

Ports:
clk  in  1  system clock
rstn  in  1  reset
tick  in  1  one-clk physics strobe
jump_btn  in  1  level-sensitive jump button
floor_y  in  11  floor top under the hero, from collision
head_hit  in  1  solid block above the hero, sampled on tick
y  out  11  hero y position
vy  out  6  current speed magnitude
state  out  2  0 GROUND, 1 RISE, 2 FALL
airborne  out  1  state != GROUND
land_pulse  out  1  one-clk pulse on the clk after the tick that lands

Behaviour:
- Reset: rstn is synchronous, active-low; clock is clk. Reset values: y=GROUND_Y, vy=0, state=GROUND, airborne=0, land_pulse=0, jump_pend=0, btn_q=0.
- Edge detect: btn_q registers jump_btn every clk. A rise (jump_btn & ~btn_q) while state==GROUND sets jump_pend. Rises while airborne are ignored; there is no buffering.
- jump_pend clears on every tick, whether it was consumed or not.
- All position and velocity updates happen only on clk edges with tick=1. Outputs are registered, so there is 1 clk latency from the tick.
- GROUND, on tick, in priority order:
  - jump_pend: go to RISE, vy=JUMP_V0, y unchanged.
  - Else floor_y > y (floor dropped away): go to FALL, vy=0.
  - Else: y=floor_y.
- RISE, on tick, in priority order:
  - head_hit, or y < CEIL_Y+vy: y=max(CEIL_Y, y-vy) computed without underflow, vy=0, go to FALL.
  - Else: y=y-vy. If vy<=GRAVITY, set vy=0 and go to FALL; otherwise vy=vy-GRAVITY.
- FALL, on tick:
  - vn = min(vy+GRAVITY, MAX_FALL_V).
  - If y+vn >= floor_y (12-bit compare): y=floor_y, vy=0, go to GROUND, and land_pulse=1 on the next clk.
  - Else: y=y+vn, vy=vn.
- tick coincident with a jump_btn rise: the edge is seen on the same clk, so the jump starts on that tick.
- Reset asserted mid-air: all state returns to reset values on the next clk edge, with no landing pulse.
- State encoding 3 is illegal and recovers to GROUND with y=floor_y on the next tick.

Optional Feature:
VARIABLE_JUMP_EN.
- Defined: in RISE, if jump_btn==0 on a tick and vy > JUMP_CUT_V, vy is first clamped to JUMP_CUT_V, then the normal RISE update applies. This gives short hops.
- Undefined: jump height is fixed by JUMP_V0 and GRAVITY; jump_btn is used only for edge detection.

Test Plan:
1. Reset held 3 clks, then released, floor_y=400 → y=400, vy=0, state=0, airborne=0. Ticks with no button → no change.
2. Full jump with defaults: pulse jump_btn, then tick → RISE, vy=12.
   - After 12 more ticks: y=322, state=FALL, vy=0.
   - After 12 fall ticks: y=400, state=GROUND, land_pulse for exactly 1 clk.
3. Ceiling: CEIL_Y=380, jump → on the 2nd RISE tick y=380, state=FALL, vy=0. head_hit=1 at the first RISE tick gives an identical FALL entry.
4. Ledge/landing:
   - While GROUND at y=400, floor_y changes to 450 → FALL on the next tick, vy grows 1,2,..., lands at exactly y=450.
   - Terminal speed: floor_y=1000, 20 fall ticks → vy saturates at 12.
5. Airborne press ignored and mid-air reset:
   - jump_btn rise during RISE → no re-jump; jump_pend stays 0.
   - rstn low while airborne → next clk y=400, state=0, vy=0.
6. VARIABLE_JUMP_EN: release jump_btn after the 2nd RISE tick (vy=10) → next tick vy clamps to 4, y drops 4. Apex at y=400-12-11-4-3-2-1=367.

Source files
------------

// File: rtl/mario_jump_ctrl.sv
// mario_jump_ctrl: hero vertical motion (ground/rise/fall) on physics ticks.
// Optional short-hop build: define VARIABLE_JUMP_EN (uses JUMP_CUT_V).
//
// Ports:
//   clk, rstn   clock, synchronous active-low reset
//   tick        one-clk physics strobe; all motion updates happen on it
//   jump_btn    level jump button (rising edge starts a jump from GROUND)
//   floor_y     floor top under the hero (11-bit, y grows downward)
//   head_hit    solid block above the hero, sampled on tick while rising
//   y, vy       hero y position and speed magnitude
//   state       0 GROUND, 1 RISE, 2 FALL
//   airborne    state != GROUND
//   land_pulse  one-clk pulse registered with the landing update
module mario_jump_ctrl #(
  parameter logic [10:0] GROUND_Y   = 11'd400,
  parameter logic [10:0] CEIL_Y     = 11'd16,
  parameter logic [5:0]  JUMP_V0    = 6'd12,
  parameter logic [5:0]  GRAVITY    = 6'd1,
  parameter logic [5:0]  MAX_FALL_V = 6'd12
`ifdef VARIABLE_JUMP_EN
  , parameter logic [5:0] JUMP_CUT_V = 6'd4
`endif
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        tick,
  input  logic        jump_btn,
  input  logic [10:0] floor_y,
  input  logic        head_hit,
  output logic [10:0] y,
  output logic [5:0]  vy,
  output logic [1:0]  state,
  output logic        airborne,
  output logic        land_pulse
);

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2,
    BAD    = 2'd3
  } st_t;

  st_t         st_q, st_d;
  logic [10:0] y_q, y_d;
  logic [5:0]  vy_q, vy_d;
  logic        land_q, land_d;
  logic        jump_pend, pend_d;
  logic        btn_q;

  logic        rise;
  logic        pend_eff;
  logic [5:0]  v_eff;
  logic [6:0]  vsum;
  logic [5:0]  vn;
  logic [11:0] ceil_lim;
  logic [11:0] y_fall;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      st_q      <= GROUND;
      y_q       <= GROUND_Y;
      vy_q      <= 6'd0;
      land_q    <= 1'b0;
      jump_pend <= 1'b0;
      btn_q     <= 1'b0;
    end else begin
      st_q      <= st_d;
      y_q       <= y_d;
      vy_q      <= vy_d;
      land_q    <= land_d;
      jump_pend <= pend_d;
      btn_q     <= jump_btn;
    end
  end

  always_comb begin
    st_d   = st_q;
    y_d    = y_q;
    vy_d   = vy_q;
    land_d = 1'b0;
    pend_d = jump_pend;

    // A rise on the tick clk itself counts for that tick.
    rise     = jump_btn & ~btn_q;
    pend_eff = jump_pend | (rise & (st_q == GROUND));

    v_eff = vy_q;
`ifdef VARIABLE_JUMP_EN
    if (!jump_btn && (vy_q > JUMP_CUT_V))
      v_eff = JUMP_CUT_V;
`endif

    vsum     = {1'b0, vy_q} + {1'b0, GRAVITY};
    vn       = (vsum > {1'b0, MAX_FALL_V}) ?
               MAX_FALL_V : vsum[5:0];
    ceil_lim = {1'b0, CEIL_Y} + {6'd0, v_eff};
    y_fall   = {1'b0, y_q} + {6'd0, vn};

    if (!tick) begin
      pend_d = pend_eff;
    end else begin
      pend_d = 1'b0;
      unique case (st_q)
        GROUND: begin
          if (pend_eff) begin
            st_d = RISE;
            vy_d = JUMP_V0;
          end else if (floor_y > y_q) begin
            st_d = FALL;
            vy_d = 6'd0;
          end else begin
            y_d = floor_y;
          end
        end
        RISE: begin
          if (head_hit || ({1'b0, y_q} < ceil_lim)) begin
            // Clamp at the ceiling without wrapping below zero.
            y_d  = ({1'b0, y_q} >= ceil_lim) ?
                   (y_q - {5'd0, v_eff}) : CEIL_Y;
            vy_d = 6'd0;
            st_d = FALL;
          end else begin
            y_d = y_q - {5'd0, v_eff};
            if (v_eff <= GRAVITY) begin
              vy_d = 6'd0;
              st_d = FALL;
            end else begin
              vy_d = v_eff - GRAVITY;
            end
          end
        end
        FALL: begin
          if (y_fall >= {1'b0, floor_y}) begin
            y_d    = floor_y;
            vy_d   = 6'd0;
            st_d   = GROUND;
            land_d = 1'b1;
          end else begin
            y_d  = y_fall[10:0];
            vy_d = vn;
          end
        end
        BAD: begin
          st_d = GROUND;
          y_d  = floor_y;
          vy_d = 6'd0;
        end
      endcase
    end
  end

  always_comb begin
    y          = y_q;
    vy         = vy_q;
    state      = st_q;
    airborne   = (st_q != GROUND);
    land_pulse = land_q;
  end

endmodule

// File: tb/tb_mario_jump_ctrl.sv
// tb_mario_jump_ctrl: randomized scoreboard bench for mario_jump_ctrl.
// Model follows the motion rules with integer arithmetic.
module tb_mario_jump_ctrl;

  localparam int GND_Y = 400;
  localparam int CEIL  = 16;
  localparam int V0    = 12;
  localparam int G     = 1;
  localparam int VMAX  = 12;
  localparam int CUT   = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        tick;
  logic        jump_btn;
  logic [10:0] floor_y;
  logic        head_hit;
  logic [10:0] y;
  logic [5:0]  vy;
  logic [1:0]  state;
  logic        airborne;
  logic        land_pulse;

  mario_jump_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .tick       (tick),
    .jump_btn   (jump_btn),
    .floor_y    (floor_y),
    .head_hit   (head_hit),
    .y          (y),
    .vy         (vy),
    .state      (state),
    .airborne   (airborne),
    .land_pulse (land_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] y;
    logic [5:0]  vy;
    logic [1:0]  st;
    logic        air;
    logic        land;
  } obs_t;

  obs_t exp_q[$];
  obs_t e_obs, a_obs;
  int   checks   = 0;
  int   failures = 0;

  // Reference model: position, speed, mode (0 ground, 1 rise, 2 fall).
  int m_y, m_vy, m_st;
  bit m_pend, m_btnq, m_land;

  task automatic model(input bit r, input bit b, input bit t,
                       input int f, input bit h);
    bit rs, pe;
    int v, vn;
    if (!r) begin
      m_y = GND_Y; m_vy = 0; m_st = 0;
      m_pend = 0; m_btnq = 0; m_land = 0;
      return;
    end
    rs = b && !m_btnq;
    pe = m_pend || (rs && m_st == 0);
    m_land = 0;
    if (t) begin
      if (m_st == 0) begin
        if (pe) begin
          m_st = 1; m_vy = V0;
        end else if (f > m_y) begin
          m_st = 2; m_vy = 0;
        end else begin
          m_y = f;
        end
      end else if (m_st == 1) begin
        v = m_vy;
`ifdef VARIABLE_JUMP_EN
        if (!b && v > CUT) v = CUT;
`endif
        if (h || m_y < CEIL + v) begin
          m_y = (m_y - v < CEIL) ? CEIL : m_y - v;
          m_vy = 0; m_st = 2;
        end else begin
          m_y = m_y - v;
          if (v <= G) begin
            m_vy = 0; m_st = 2;
          end else begin
            m_vy = v - G;
          end
        end
      end else begin
        vn = (m_vy + G > VMAX) ? VMAX : m_vy + G;
        if (m_y + vn >= f) begin
          m_y = f; m_vy = 0; m_st = 0; m_land = 1;
        end else begin
          m_y = m_y + vn; m_vy = vn;
        end
      end
      m_pend = 0;
    end else begin
      m_pend = pe;
    end
    m_btnq = b;
  endtask

  task automatic step(input bit r, input bit b, input bit t,
                      input int f, input bit h);
    obs_t e;
    rstn = r; jump_btn = b; tick = t;
    floor_y = f[10:0]; head_hit = h;
    model(r, b, t, f, h);
    e.y    = m_y[10:0];
    e.vy   = m_vy[5:0];
    e.st   = m_st[1:0];
    e.air  = (m_st != 0);
    e.land = m_land;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Tick every other clk with the button held at level b.
  task automatic ticks(input int n, input bit b, input int f);
    for (int i = 0; i < n; i++) begin
      step(1, b, 1, f, 0);
      step(1, b, 0, f, 0);
    end
  endtask

  // Monitor: outputs are registered, compare each clk after the edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e_obs = exp_q.pop_front();
        a_obs = '{y, vy, state, airborne, land_pulse};
        checks++;
        if (a_obs !== e_obs) begin
          failures++;
          $display("FAIL obs t=%0t got y=%0d vy=%0d st=%0d air=%0b land=%0b want y=%0d vy=%0d st=%0d air=%0b land=%0b",
                   $time, a_obs.y, a_obs.vy, a_obs.st, a_obs.air,
                   a_obs.land, e_obs.y, e_obs.vy, e_obs.st,
                   e_obs.air, e_obs.land);
        end
      end
    end
  end

  initial begin
    bit r, b, t, h;
    int f;
    m_btnq = 0;
    // Reset for 3 clks, then idle ticks on the ground.
    repeat (3) step(0, 0, 0, 400, 0);
    ticks(3, 0, 400);
    // Full jump with the button held; then release for the fall.
    step(1, 1, 0, 400, 0);
    ticks(13, 1, 400);
    ticks(14, 0, 400);
    repeat (3) step(1, 0, 0, 400, 0);
    // Rise coincident with a tick, release early.
    step(1, 1, 1, 400, 0);
    step(1, 1, 0, 400, 0);
    ticks(2, 1, 400);
    ticks(30, 0, 400);
    // Head hit on the first rise tick.
    step(1, 1, 1, 400, 0);
    step(1, 1, 1, 400, 1);
    ticks(30, 0, 400);
    // Ceiling clamp: ground near the top of the screen.
    ticks(2, 0, 30);
    step(1, 1, 1, 30, 0);
    ticks(4, 1, 30);
    ticks(6, 0, 30);
    // Ledge drop to 450, then deep fall to 1000 for terminal speed.
    ticks(2, 0, 400);
    ticks(40, 0, 450);
    ticks(70, 0, 1000);
    // Re-press while rising is ignored.
    step(1, 1, 1, 1000, 0);
    ticks(2, 1, 1000);
    ticks(1, 0, 1000);
    ticks(2, 1, 1000);
    ticks(3, 0, 1000);
    // Reset while airborne.
    step(0, 0, 0, 1000, 0);
    step(1, 0, 0, 1000, 0);
    ticks(80, 0, 1000);
    // Randomized phase.
    b = 0;
    f = 400;
    for (int i = 0; i < 5000; i++) begin
      r = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 7) == 0) b = ~b;
      t = ($urandom_range(0, 2) == 0);
      h = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 249) == 0) begin
        case ($urandom_range(0, 4))
          0: f = 400;
          1: f = 450;
          2: f = 30;
          3: f = 1000;
          default: f = int'($urandom_range(20, 1500));
        endcase
      end
      step(r, b, t, f, h);
    end
    step(1, 0, 0, f, 0);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
